data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Single-port data memory with WAIT_CYCLES wait states and a one-cycle ack per access.
// Define DMEM_ALIGN_CHECK_EN to add the err port and reject misaligned accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        RW,
  input  logic [31:0] address,
  input  logic [31:0] DataIn,
  output logic        ack,
  output logic [31:0] DataOut,
  output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rw_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     data_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            capture;
  logic            enterResp;
  logic            accRw;
  logic [AW+1:0]   accAddr;
  logic [31:0]     accData;
  logic [AW-1:0]   accIdx;
  logic            misaligned;
  logic            unusedBits;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    enterResp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            enterResp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          enterResp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access completes on its capture edge, so use the live inputs then.
  assign accRw   = capture ? RW : rw_q;
  assign accAddr = capture ? address[AW+1:0] : addr_q;
  assign accData = capture ? DataIn : data_q;
  assign accIdx  = accAddr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (accAddr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign unusedBits = ^{address[31:AW+2], accAddr[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      DataOut <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack     <= enterResp;
      busy    <= (state_d != IDLE);
`ifdef DMEM_ALIGN_CHECK_EN
      err     <= enterResp & misaligned;
`endif
      if (enterResp && !accRw) begin
        DataOut <= misaligned ? 32'd0 : mem[accIdx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (capture) begin
      rw_q   <= RW;
      addr_q <= address[AW+1:0];
      data_q <= DataIn;
    end
  end

  // Gated by RST so an access abandoned by reset never reaches storage.
  always_ff @(posedge CLK) begin
    if (!RST && enterResp && accRw && !misaligned) begin
      mem[accIdx] <= accData;
    end
  end

endmodule
